// File: rtl/ldst_rsp_unit.sv
// Load/store responder: turns one execution-unit request at a time into a
// word-aligned dmem transaction and returns one extended-data or error response.
module ldst_rsp_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ldst_req_vld,
  output logic              ldst_req_rdy,
  input  logic              ldst_req_st,
  input  logic [1:0]        ldst_req_size,
  input  logic              ldst_req_sext,
  input  logic [ADDR_W-1:0] ldst_req_addr,
  input  logic [31:0]       ldst_req_wdata,
  output logic              ldst_rsp_vld,
  input  logic              ldst_rsp_rdy,
  output logic [31:0]       ldst_rsp_rdata,
  output logic              ldst_rsp_err,
  output logic              dmem_req_vld,
  input  logic              dmem_req_rdy,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [3:0]        dmem_req_wstrb,
  output logic [31:0]       dmem_req_wdata,
  input  logic              dmem_rsp_vld,
  input  logic [31:0]       dmem_rsp_rdata,
  input  logic              dmem_rsp_err
);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RSP} state_t;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q;
  logic              st_q, sext_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept, req_bad, tmo_hit;
  logic [3:0]        lane_mask;
  logic [31:0]       wdata_rep, lane, ld_ext;

  assign accept  = (state_q == IDLE) && ldst_req_vld;
  assign req_bad = (ldst_req_size == 2'd3) ||
                   ((ldst_req_size == 2'd1) && ldst_req_addr[0]) ||
                   ((ldst_req_size == 2'd2) && (ldst_req_addr[1:0] != 2'b00));
  assign tmo_hit = (TIMEOUT != 0) && (state_q == MWAIT) && (timer_q == TMO_LAST);

  // Lane mask doubles as the write strobe and the load lane select.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    lane_mask = 4'b1111;
    wdata_rep = ldst_req_wdata;
    case (ldst_req_size)
      2'd0: begin
        lane_mask = 4'b0001 << ldst_req_addr[1:0];
        wdata_rep = {4{ldst_req_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask = 4'b0011 << ldst_req_addr[1:0];
        wdata_rep = {2{ldst_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dmem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = lane;
    case (size_q)
      2'd0:    ld_ext = {{24{sext_q & lane[7]}}, lane[7:0]};
      2'd1:    ld_ext = {{16{sext_q & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ldst_req_vld) state_d = req_bad ? RSP : MREQ;
      MREQ:    if (dmem_req_rdy) state_d = MWAIT;
      MWAIT:   if (dmem_rsp_vld || tmo_hit) state_d = RSP;
      RSP:     if (ldst_rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if ((state_q == MREQ) && dmem_req_rdy) begin
      timer_q <= '0;
    end else if (state_q == MWAIT) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        st_q    <= ldst_req_st;
        sext_q  <= ldst_req_sext;
        size_q  <= ldst_req_size;
        off_q   <= ldst_req_addr[1:0];
        addr_q  <= {ldst_req_addr[ADDR_W-1:2], 2'b00};
        wstrb_q <= lane_mask;
        wdata_q <= wdata_rep;
        if (req_bad) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end
      end
      // A real response beats a timeout firing in the same cycle.
      if (state_q == MWAIT) begin
        if (dmem_rsp_vld) begin
          err_q   <= dmem_rsp_err;
          rdata_q <= (dmem_rsp_err || st_q) ? 32'd0 : ld_ext;
        end else if (tmo_hit) begin
          err_q   <= 1'b1;
          rdata_q <= 32'd0;
        end
      end
    end
  end

  assign ldst_req_rdy   = (state_q == IDLE);
  assign ldst_rsp_vld   = (state_q == RSP);
  assign ldst_rsp_rdata = rdata_q;
  assign ldst_rsp_err   = err_q;
  assign dmem_req_vld   = (state_q == MREQ);
  assign dmem_req_we    = st_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wstrb = wstrb_q;
  assign dmem_req_wdata = wdata_q;

endmodule

// File: tb/tb_ldst_rsp_unit.sv
// Scoreboard bench for ldst_rsp_unit: a driver pushes expected dmem and response
// transactions; a memory responder and a response monitor pop and compare them.
module tb_ldst_rsp_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ldst_req_vld, ldst_req_rdy, ldst_req_st, ldst_req_sext;
  logic [1:0]        ldst_req_size;
  logic [ADDR_W-1:0] ldst_req_addr;
  logic [31:0]       ldst_req_wdata;
  logic              ldst_rsp_vld, ldst_rsp_rdy, ldst_rsp_err;
  logic [31:0]       ldst_rsp_rdata;
  logic              dmem_req_vld, dmem_req_rdy, dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [3:0]        dmem_req_wstrb;
  logic [31:0]       dmem_req_wdata;
  logic              dmem_rsp_vld, dmem_rsp_err;
  logic [31:0]       dmem_rsp_rdata;

  ldst_rsp_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ldst_req_vld(ldst_req_vld), .ldst_req_rdy(ldst_req_rdy),
    .ldst_req_st(ldst_req_st), .ldst_req_size(ldst_req_size),
    .ldst_req_sext(ldst_req_sext), .ldst_req_addr(ldst_req_addr),
    .ldst_req_wdata(ldst_req_wdata),
    .ldst_rsp_vld(ldst_rsp_vld), .ldst_rsp_rdy(ldst_rsp_rdy),
    .ldst_rsp_rdata(ldst_rsp_rdata), .ldst_rsp_err(ldst_rsp_err),
    .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_vld(dmem_rsp_vld), .dmem_rsp_rdata(dmem_rsp_rdata),
    .dmem_rsp_err(dmem_rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        merr;
    int          lat;
    int          mstall;
    int          rstall;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stall;
  } mem_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derive the dmem transaction and the response from the rules.
  task automatic predict(input req_t r, output bit bad);
    int unsigned off;
    logic [31:0] lane, v;
    mem_t m;
    rsp_t e;
    off = r.addr % 4;
    bad = (r.size == 3) || (r.size == 1 && off % 2 != 0) || (r.size == 2 && off != 0);
    e.stall = r.rstall;
    if (bad) begin
      e.rdata = 0;
      e.err   = 1;
    end else begin
      m.addr  = r.addr - off;
      m.we    = r.st;
      m.strb  = (r.size == 0) ? 4'(1 << off) : (r.size == 1) ? 4'(3 << off) : 4'hF;
      m.wdata = (r.size == 0) ? (r.wdata % 256) * 32'h0101_0101 :
                (r.size == 1) ? (r.wdata % 65536) * 32'h0001_0001 : r.wdata;
      m.rdata = r.mrdata;
      m.err   = r.merr;
      m.lat   = r.lat;
      m.stall = r.mstall;
      mem_q.push_back(m);
      if (r.lat >= TIMEOUT) begin
        e.rdata = 0;
        e.err   = 1;
      end else if (r.merr || r.st) begin
        e.rdata = 0;
        e.err   = r.merr;
      end else begin
        lane = r.mrdata >> (8 * off);
        v = lane;
        if (r.size == 0) begin
          v = lane % 256;
          if (r.sext && v >= 128) v = v - 256;
        end else if (r.size == 1) begin
          v = lane % 65536;
          if (r.sext && v >= 32768) v = v - 65536;
        end
        e.rdata = v;
        e.err   = 0;
      end
    end
    rsp_q.push_back(e);
  endtask

  task automatic send(input req_t r);
    bit bad;
    int w;
    w = 0;
    @(negedge clk);
    while (!ldst_req_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ldst_req_rdy) begin
      check("req_rdy_wait", ldst_req_rdy, 1);
      return;
    end
    predict(r, bad);
    ldst_req_vld   = 1;
    ldst_req_st    = r.st;
    ldst_req_size  = r.size;
    ldst_req_sext  = r.sext;
    ldst_req_addr  = r.addr;
    ldst_req_wdata = r.wdata;
    @(posedge clk);
    #1;
    ldst_req_vld = 0;
    if (bad) begin
      @(negedge clk);
      check("bad_rsp_next_cycle", ldst_rsp_vld, 1);
      check("bad_no_dmem", dmem_req_vld, 0);
    end
  endtask

  function automatic req_t mk(input logic st, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrdata, input int lat,
                              input int mstall, input int rstall);
    req_t r;
    r.st = st; r.size = size; r.sext = sext; r.addr = addr; r.wdata = wdata;
    r.mrdata = mrdata; r.merr = 0; r.lat = lat; r.mstall = mstall; r.rstall = rstall;
    return r;
  endfunction

  // Memory responder: compares each dmem request, then answers after m.lat cycles.
  initial begin
    mem_t m;
    dmem_req_rdy = 0; dmem_rsp_vld = 0; dmem_rsp_rdata = 0; dmem_rsp_err = 0;
    forever begin
      @(negedge clk);
      if (dmem_req_vld && rst_n) begin
        if (mem_q.size() == 0) begin
          check("unexpected_dmem_req", dmem_req_vld, 0);
          dmem_req_rdy = 1;
          @(posedge clk);
          #1 dmem_req_rdy = 0;
        end else begin
          m = mem_q.pop_front();
          for (int s = 0; ; s++) begin
            check("dmem_vld", dmem_req_vld, 1);
            check("dmem_addr", dmem_req_addr, m.addr);
            check("dmem_we", dmem_req_we, m.we);
            check("dmem_wstrb", dmem_req_wstrb, m.strb);
            check("dmem_wdata", dmem_req_wdata, m.wdata);
            check("req_rdy_in_mreq", ldst_req_rdy, 0);
            if (s == m.stall) break;
            @(negedge clk);
          end
          dmem_req_rdy = 1;
          @(posedge clk);
          #1 dmem_req_rdy = 0;
          for (int c = 0; ; c++) begin
            if (c == m.lat) begin
              dmem_rsp_vld   = 1;
              dmem_rsp_rdata = m.rdata;
              dmem_rsp_err   = m.err;
            end
            @(negedge clk);
            if (m.lat >= TIMEOUT && c == TIMEOUT - 1) check("tmo_not_early", ldst_rsp_vld, 0);
            if (m.lat >= TIMEOUT && c == TIMEOUT)     check("tmo_on_time", ldst_rsp_vld, 1);
            @(posedge clk);
            #1;
            dmem_rsp_vld   = 0;
            dmem_rsp_rdata = 0;
            dmem_rsp_err   = 0;
            if (c == m.lat) break;
          end
        end
      end
    end
  end

  // Response monitor: compares every presented response, holding rdy low for e.stall cycles.
  initial begin
    rsp_t e;
    ldst_rsp_rdy = 0;
    forever begin
      @(negedge clk);
      if (ldst_rsp_vld && rst_n) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", ldst_rsp_vld, 0);
          ldst_rsp_rdy = 1;
          @(posedge clk);
          #1 ldst_rsp_rdy = 0;
        end else begin
          e = rsp_q.pop_front();
          for (int s = 0; ; s++) begin
            check("rsp_vld", ldst_rsp_vld, 1);
            check("rsp_rdata", ldst_rsp_rdata, e.rdata);
            check("rsp_err", ldst_rsp_err, e.err);
            check("req_rdy_in_rsp", ldst_req_rdy, 0);
            if (s == e.stall) break;
            @(negedge clk);
          end
          ldst_rsp_rdy = 1;
          @(posedge clk);
          #1 ldst_rsp_rdy = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   w;
    rst_n = 0;
    ldst_req_vld = 0; ldst_req_st = 0; ldst_req_size = 0; ldst_req_sext = 0;
    ldst_req_addr = 0; ldst_req_wdata = 0;
    #2;
    check("rst_req_rdy", ldst_req_rdy, 1);
    check("rst_rsp_vld", ldst_rsp_vld, 0);
    check("rst_rsp_rdata", ldst_rsp_rdata, 0);
    check("rst_rsp_err", ldst_rsp_err, 0);
    check("rst_dmem_vld", dmem_req_vld, 0);
    check("rst_dmem_we", dmem_req_we, 0);
    check("rst_dmem_addr", dmem_req_addr, 0);
    check("rst_dmem_wstrb", dmem_req_wstrb, 0);
    check("rst_dmem_wdata", dmem_req_wdata, 0);
    #15 rst_n = 1;
    repeat (2) @(posedge clk);

    send(mk(0, 0, 1, 32'h1003, 0, 32'h80AA_BBCC, 0, 0, 0));
    send(mk(0, 1, 0, 32'h2002, 0, 32'h9234_5678, 1, 0, 0));
    send(mk(0, 1, 1, 32'h2002, 0, 32'h9234_5678, 2, 0, 0));
    send(mk(1, 0, 0, 32'h3001, 32'h0000_00A5, 32'h1234_5678, 0, 0, 0));
    send(mk(0, 2, 0, 32'h4002, 0, 0, 0, 0, 0));
    send(mk(0, 3, 0, 32'h4000, 0, 0, 0, 0, 0));
    send(mk(0, 2, 0, 32'h5000, 0, 32'hDEAD_BEEF, 1, 5, 3));
    send(mk(1, 1, 0, 32'h5002, 32'h0000_C3D4, 0, 0, 1, 2));
    send(mk(0, 2, 0, 32'h6000, 0, 32'h0BAD_F00D, 5, 0, 0));
    send(mk(0, 2, 0, 32'h6004, 0, 32'h1357_9BDF, 3, 0, 0));
    r = mk(0, 2, 0, 32'h7000, 0, 32'hFFFF_FFFF, 1, 0, 0);
    r.merr = 1;
    send(r);

    for (int i = 0; i < 80; i++) begin
      r.st     = 1'($urandom_range(0, 1));
      r.size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r.sext   = 1'($urandom_range(0, 1));
      r.addr   = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (r.size == 1) r.addr[0] = 1'b0;
        if (r.size == 2) r.addr[1:0] = 2'b00;
      end
      r.wdata  = $urandom;
      r.mrdata = $urandom;
      r.merr   = ($urandom_range(0, 7) == 0);
      r.lat    = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 2)
                                             : $urandom_range(0, TIMEOUT - 1);
      r.mstall = $urandom_range(0, 2);
      r.rstall = $urandom_range(0, 2);
      send(r);
    end

    w = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0 || !ldst_req_rdy) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_rsp_q", rsp_q.size(), 0);
    check("drain_mem_q", mem_q.size(), 0);
    check("final_idle", ldst_req_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ldst_rsp_unit.md
Name: ldst_rsp_unit

Overview:
Data-side responder for the execution unit's load/store request channel. Accepts one load or store request at a time and checks alignment. Converts the request into a word-aligned data-memory bus transaction with byte strobes, then returns a single response carrying extended load data or an error. Sits between the execution unit and the data memory / bus fabric.

Parameters:
ADDR_W, 32, byte address width of request and dmem bus
TIMEOUT, 255, cycles to wait in MWAIT for dmem_rsp_vld before an error response; 0 disables the timeout

Ports:
clk  in  1  core clock
rst_n  in  1  reset
ldst_req_vld  in  1  request valid from execution unit
ldst_req_rdy  out  1  request accepted when vld&rdy
ldst_req_st  in  1  1=store, 0=load
ldst_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
ldst_req_sext  in  1  loads: 1=sign-extend, 0=zero-extend
ldst_req_addr  in  ADDR_W  byte address
ldst_req_wdata  in  32  store data, low-aligned
ldst_rsp_vld  out  1  response valid
ldst_rsp_rdy  in  1  response consumed when vld&rdy
ldst_rsp_rdata  out  32  extended load data; 0 for stores and errors
ldst_rsp_err  out  1  misaligned, reserved size, bus error or timeout
dmem_req_vld  out  1  memory request valid
dmem_req_rdy  in  1  memory request accepted
dmem_req_we  out  1  write enable
dmem_req_addr  out  ADDR_W  word-aligned address, addr[1:0]=0
dmem_req_wstrb  out  4  byte lane strobes
dmem_req_wdata  out  32  lane-replicated write data
dmem_rsp_vld  in  1  memory response valid, single-cycle pulse
dmem_rsp_rdata  in  32  read word
dmem_rsp_err  in  1  bus error

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, timer=0, all captured fields=0. ldst_req_rdy=1. All other outputs are 0.
- FSM states: IDLE, MREQ, MWAIT, RSP. Outputs are registered or decoded from state only; no combinational path from any input to any output.
- IDLE:
  - ldst_req_rdy=1.
  - On vld, capture st, size, sext, addr and wdata.
  - If size==3, or half with addr[0]!=0, or word with addr[1:0]!=0: go to RSP with err=1 and rdata=0. No dmem access is made.
  - Otherwise go to MREQ.
- MREQ:
  - dmem_req_vld=1; fields are held stable until dmem_req_rdy.
  - dmem_req_addr = {addr[ADDR_W-1:2],2'b00}; we=st.
  - wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. For loads wstrb equals the same lane mask.
  - wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
  - On dmem_req_rdy go to MWAIT and clear the timer.
- MWAIT:
  - Timer increments each cycle.
  - On dmem_rsp_vld go to RSP with err=dmem_rsp_err.
  - Load data (err=0): lane = dmem_rsp_rdata >> (8*addr[1:0]); byte lane[7:0], half lane[15:0]. Extend per sext.
  - Stores, or err=1: rdata=0.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 without dmem_rsp_vld: go to RSP with err=1, rdata=0.
  - If dmem_rsp_vld and the timeout fire in the same cycle, the response wins.
- RSP:
  - ldst_rsp_vld=1; rdata/err are held until ldst_rsp_rdy, then return to IDLE.
  - ldst_req_rdy=0 in MREQ, MWAIT and RSP. Throughput is at most one request per 4 cycles; a minimum load takes 1 cycle each in IDLE, MREQ, MWAIT and RSP.
- dmem_rsp_vld outside MWAIT is ignored; this includes a late response after a timeout.
- Reset mid-operation aborts the transaction immediately: vld outputs drop asynchronously and no response is generated.

Test Plan:
- Load byte, sext=1, addr=0x1003, dmem_rsp_rdata=0x80AABBCC -> dmem_req_addr=0x1000, wstrb=4'b1000; ldst_rsp_rdata=0xFFFFFF80, err=0.
- Load half, sext=0, addr=0x2002, rdata=0x9234_5678 -> ldst_rsp_rdata=0x00009234. With sext=1 -> 0xFFFF9234.
- Store byte, addr=0x3001, wdata=0x000000A5 -> we=1, wstrb=4'b0010, dmem_req_wdata=0xA5A5A5A5; response rdata=0, err=0.
- Misaligned word load, addr=0x4002 -> no dmem_req_vld ever asserts; ldst_rsp_vld the cycle after accept with err=1. Repeat with size=3 -> same result.
- Back-pressure: dmem_req_rdy low 5 cycles, ldst_rsp_rdy low 3 cycles -> dmem request fields and response fields stay stable; ldst_req_rdy stays 0 throughout.
- Timeout: TIMEOUT=4, no dmem_rsp_vld -> err=1 response 4 cycles after MWAIT entry. A late dmem_rsp_vld is ignored, and the next request completes normally.
